// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - four-phase request/ack memory responder with configurable latency.
// Optional write trace enabled by DM_RESPONDER_WRITE_TRACE_EN.
module dm_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           we_q, we_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    mem_q [2**AW];
    logic           mem_we;
    logic           fault;
    logic [AW-1:0]  widx;

    assign fault = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign widx  = addr_q[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_WAIT;
            S_WAIT: begin
                if (!req)               state_d = S_IDLE;
                else if (cnt_q == 4'd0) state_d = S_ACK;
            end
            S_ACK:   if (!req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture happens only in IDLE, so input changes while req is high never reach the datapath.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        if (state_q == S_IDLE && req) begin
            cnt_d   = 4'(LATENCY - 1);
            addr_d  = addr;
            wdata_d = wdata;
            we_d    = we;
        end
        if (state_q == S_WAIT) begin
            if (!req)
                cnt_d = '0;
            else if (cnt_q != 4'd0)
                cnt_d = cnt_q - 4'd1;
        end
        if (state_q == S_WAIT && state_d == S_ACK) begin
            err_d   = fault;
            rdata_d = (!fault && !we_q) ? mem_q[widx] : '0;
            mem_we  = we_q && !fault;
        end
        if (state_q == S_ACK && state_d == S_IDLE) begin
            err_d   = 1'b0;
            rdata_d = '0;
        end
    end

    always_comb begin
        ack   = (state_q == S_ACK);
        err   = err_q;
        rdata = rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**AW; i++)
                mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[widx] <= wdata_q;
        end
    end

`ifdef DM_RESPONDER_WRITE_TRACE_EN
    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (state_q == S_IDLE && req)
            pc_d = pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we)
            $display("@%08h: *%08h <= %08h", pc_q, addr_q, wdata_q);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder.
module tb_dm_responder;

    localparam int LAT = 2;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata, pc;
    logic        ack, err;
    logic [31:0] rdata;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t cur;
    logic have = 1'b0;
    logic ack_prev = 1'b0;

    dm_responder #(.LATENCY(LAT), .AW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .pc    (pc),
        .ack   (ack),
        .err   (err),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ack && !ack_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
                have = 1'b0;
            end else begin
                cur  = sb.pop_front();
                have = 1'b1;
            end
        end
        if (ack && have) begin
            check("resp_err", {31'd0, err}, {31'd0, cur.err});
            if (cur.chk_rd)
                check("resp_rdata", rdata, cur.rdata);
        end
        if (!ack) have = 1'b0;
        ack_prev = ack;
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p, input int hold,
                       input logic e_err, input logic [31:0] e_rd);
        int n;
        exp_t e;
        e.err    = e_err;
        e.chk_rd = !w || e_err;
        e.rdata  = e_rd;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; pc = p;
        @(posedge clk); #1;
        we = ~w; addr = a ^ 32'h8; wdata = ~d; pc = '0;
        n = 0;
        while (!ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ack_latency", n, LAT);
        for (int k = 1; k < hold; k++) begin
            @(posedge clk); #1;
            check("ack_hold", {31'd0, ack}, 32'd1);
        end
        req = 1'b0;
        @(posedge clk); #1;
        check("ack_drop", {31'd0, ack}, 32'd0);
        check("rdata_idle", rdata, 32'd0);
        check("err_idle", {31'd0, err}, 32'd0);
    endtask

    task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("abort_no_ack", {31'd0, ack}, 32'd0);
        end
    endtask

    task automatic reset_mid_wait(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; pc = '0;
        #1;
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        txn(1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0, 3, 1'b0, 32'h0);
        txn(1'b0, 32'h0000_0004, 32'h0,         32'h0, 2, 1'b0, 32'h1234_5678);
        txn(1'b0, 32'h0000_0FFC, 32'h0,         32'h0, 1, 1'b0, 32'h0);
        txn(1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 32'h0, 1, 1'b1, 32'h0);
        txn(1'b0, 32'h0000_1000, 32'h0,         32'h0, 1, 1'b1, 32'h0);
        txn(1'b1, 32'h8000_0004, 32'h5555_AAAA, 32'h0, 1, 1'b1, 32'h0);
        txn(1'b0, 32'h0000_0004, 32'h0,         32'h0, 1, 1'b0, 32'h1234_5678);

        abort_write(32'h0000_0008, 32'hCAFE_0000);
        txn(1'b0, 32'h0000_0008, 32'h0, 32'h0, 1, 1'b0, 32'h0);

        txn(1'b1, 32'h0000_0010, 32'h0000_00AB, 32'h0000_3000, 1, 1'b0, 32'h0);
        txn(1'b0, 32'h0000_0010, 32'h0,         32'h0,         1, 1'b0, 32'h0000_00AB);

        reset_mid_wait(32'h0000_000C, 32'hFFFF_FFFF);
        txn(1'b0, 32'h0000_000C, 32'h0, 32'h0, 1, 1'b0, 32'h0);
        txn(1'b0, 32'h0000_0004, 32'h0, 32'h0, 1, 1'b0, 32'h0);
        txn(1'b0, 32'h0000_0010, 32'h0, 32'h0, 1, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
